// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe
//
// Two-stage register-file / ALU datapath.
// Stage 1 reads operands, with forwarding from the EX register, and computes the result.
// Stage 2 holds the result in the EX register for one cycle and then commits it to the
// register file. A shift-add multiplier takes one bit of the multiplier per cycle and
// stalls issue through the busy output while it runs.
//
// Ports:
//   clk, rst_n          rising-edge clock; asynchronous active-low reset
//   valid_in            issue request, taken on an edge where busy is low
//   write               commit the result to rDst
//   IMM_MUX             operand B source: 1 = imm, 0 = R[rSrc]
//   MEM_MUX             result is mem_data; the ALU is bypassed and the PSR is left alone
//   rSrc, rDst          source and destination register indices
//   aluOp               5-bit operation code
//   pc, imm, mem_data   PC of the issuing instruction, extended immediate, load data
//   dSrc, dDst          forwarded register values (combinational)
//   psrOut              {N,Z,F,L,C}
//   busy                a multiply is in progress and issue is ignored
//   wb_valid, wb_data   a write is pending in EX, and its value

module reg_alu_pipe #(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 16,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              write,
    input  logic              IMM_MUX,
    input  logic              MEM_MUX,
    input  logic [RA_W-1:0]   rSrc,
    input  logic [RA_W-1:0]   rDst,
    input  logic [4:0]        aluOp,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] dSrc,
    output logic [DATA_W-1:0] dDst,
    output logic [4:0]        psrOut,
    output logic              busy,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data
);

    localparam int MSB   = DATA_W - 1;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_XOR  = 5'h04;
    localparam logic [4:0] OP_MOV  = 5'h05;
    localparam logic [4:0] OP_CMP  = 5'h06;
    localparam logic [4:0] OP_LSH  = 5'h07;
    localparam logic [4:0] OP_RSH  = 5'h08;
    localparam logic [4:0] OP_MUL  = 5'h09;
    localparam logic [4:0] OP_LINK = 5'h0A;

    // PSR bit positions
    localparam int PSR_N = 4;
    localparam int PSR_Z = 3;
    localparam int PSR_F = 2;
    localparam int PSR_L = 1;
    localparam int PSR_C = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [RA_W-1:0]   mulDst_q, mulDst_d;
    logic              mulWrite_q, mulWrite_d;

    logic              exValid_q, exValid_d;
    logic [RA_W-1:0]   exDst_q, exDst_d;
    logic [DATA_W-1:0] exData_q, exData_d;

    logic [4:0]        psr_q, psr_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W:0]   addFull;
    logic [DATA_W-1:0] subRes;
    logic [SH_W-1:0]   shAmt;
    logic [DATA_W-1:0] aluRes;
    logic              aluWr;
    logic              setZN;
    logic [4:0]        aluPsr;
    logic [DATA_W-1:0] mulStep;

    // The EX register holds the only result that has not been committed yet.
    // A read that matches its destination takes the EX value. The register file
    // commits that value on the next edge, so neither path returns stale data.
    always_comb begin
        dSrc = regs_q[rSrc];
        dDst = regs_q[rDst];
        if (exValid_q && (exDst_q == rSrc)) begin
            dSrc = exData_q;
        end
        if (exValid_q && (exDst_q == rDst)) begin
            dDst = exData_q;
        end
    end

    assign opA = dDst;
    assign opB = IMM_MUX ? imm : dSrc;

    // Single-cycle ALU. It produces the result, whether the op writes at all,
    // and the PSR the op would leave behind. Flags an op does not name keep psr_q.
    always_comb begin
        addFull = {1'b0, opA} + {1'b0, opB};
        subRes  = opA - opB;
        shAmt   = opB[SH_W-1:0];
        aluRes  = '0;
        aluWr   = 1'b0;
        setZN   = 1'b0;
        aluPsr  = psr_q;
        case (aluOp)
            OP_ADD: begin
                aluRes        = addFull[MSB:0];
                aluWr         = 1'b1;
                setZN         = 1'b1;
                aluPsr[PSR_C] = addFull[DATA_W];
                aluPsr[PSR_F] = (opA[MSB] == opB[MSB]) && (addFull[MSB] != opA[MSB]);
            end
            OP_SUB: begin
                aluRes        = subRes;
                aluWr         = 1'b1;
                setZN         = 1'b1;
                aluPsr[PSR_C] = (opA < opB);
                aluPsr[PSR_F] = (opA[MSB] != opB[MSB]) && (subRes[MSB] != opA[MSB]);
            end
            OP_AND: begin
                aluRes = opA & opB;
                aluWr  = 1'b1;
                setZN  = 1'b1;
            end
            OP_OR: begin
                aluRes = opA | opB;
                aluWr  = 1'b1;
                setZN  = 1'b1;
            end
            OP_XOR: begin
                aluRes = opA ^ opB;
                aluWr  = 1'b1;
                setZN  = 1'b1;
            end
            OP_MOV: begin
                aluRes = opB;
                aluWr  = 1'b1;
                setZN  = 1'b1;
            end
            OP_CMP: begin
                aluPsr[PSR_Z] = (opA == opB);
                aluPsr[PSR_L] = (opA < opB);
                aluPsr[PSR_N] = ($signed(opA) < $signed(opB));
            end
            OP_LSH: begin
                aluRes = opA << shAmt;
                aluWr  = 1'b1;
                setZN  = 1'b1;
            end
            OP_RSH: begin
                aluRes = $signed(opA) >>> shAmt;
                aluWr  = 1'b1;
                setZN  = 1'b1;
            end
            OP_LINK: begin
                aluRes = pc + DATA_W'(1);
                aluWr  = 1'b1;
            end
            default: begin
                aluRes = '0;
            end
        endcase
        if (setZN) begin
            aluPsr[PSR_N] = aluRes[MSB];
            aluPsr[PSR_Z] = (aluRes == '0);
        end
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    assign mulStep = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Issue and multiply control. The EX register is loaded only on the edge that
    // produces a result, so wb_valid lasts exactly one cycle per write.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        mulDst_d   = mulDst_q;
        mulWrite_d = mulWrite_q;
        exValid_d  = 1'b0;
        exDst_d    = exDst_q;
        exData_d   = exData_q;
        psr_d      = psr_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    if (MEM_MUX) begin
                        exValid_d = write;
                        exDst_d   = rDst;
                        exData_d  = mem_data;
                    end else if (aluOp == OP_MUL) begin
                        state_d    = S_MUL;
                        cnt_d      = '0;
                        acc_d      = '0;
                        mcand_d    = opA;
                        mplier_d   = opB;
                        mulDst_d   = rDst;
                        mulWrite_d = write;
                    end else begin
                        exValid_d = write && aluWr;
                        exDst_d   = rDst;
                        exData_d  = aluRes;
                        psr_d     = aluPsr;
                    end
                end
            end
            S_MUL: begin
                acc_d    = mulStep;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    exValid_d    = mulWrite_q;
                    exDst_d      = mulDst_q;
                    exData_d     = mulStep;
                    psr_d[PSR_N] = mulStep[MSB];
                    psr_d[PSR_Z] = (mulStep == '0);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            mulDst_q   <= '0;
            mulWrite_q <= 1'b0;
            exValid_q  <= 1'b0;
            exDst_q    <= '0;
            exData_q   <= '0;
            psr_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            mulDst_q   <= mulDst_d;
            mulWrite_q <= mulWrite_d;
            exValid_q  <= exValid_d;
            exDst_q    <= exDst_d;
            exData_q   <= exData_d;
            psr_q      <= psr_d;
        end
    end

    // Commit stage: the EX value is written one edge after it was captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (exValid_q) begin
            regs_q[exDst_q] <= exData_q;
        end
    end

    assign busy     = (state_q == S_MUL);
    assign psrOut   = psr_q;
    assign wb_valid = exValid_q;
    assign wb_data  = exData_q;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb_reg_alu_pipe
//
// Randomised and directed bench for reg_alu_pipe (DATA_W=16, NUM_REGS=16).
// The reference model keeps the architectural register values and the PSR as plain
// integers and computes each op with ordinary arithmetic. Expected write-back entries
// go into a queue; a monitor pops one each time the DUT shows wb_valid.

module tb_reg_alu_pipe;

    localparam int     W       = 16;
    localparam int     NR      = 16;
    localparam longint MASK    = (longint'(1) << W) - 1;
    localparam longint HALF    = longint'(1) << (W - 1);
    localparam int     TIMEOUT = 200;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_MOV  = 5;
    localparam int OP_CMP  = 6;
    localparam int OP_LSH  = 7;
    localparam int OP_RSH  = 8;
    localparam int OP_MUL  = 9;
    localparam int OP_LINK = 10;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         valid_in = 1'b0;
    logic         wrEn     = 1'b0;
    logic         immMux   = 1'b0;
    logic         memMux   = 1'b0;
    logic [3:0]   rSrc     = '0;
    logic [3:0]   rDst     = '0;
    logic [4:0]   aluOp    = '0;
    logic [W-1:0] pc       = '0;
    logic [W-1:0] imm      = '0;
    logic [W-1:0] memData  = '0;
    logic [W-1:0] dSrc;
    logic [W-1:0] dDst;
    logic [W-1:0] wbData;
    logic [4:0]   psrOut;
    logic         busy;
    logic         wbValid;

    reg_alu_pipe #(
        .DATA_W   (W),
        .NUM_REGS (NR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .write    (wrEn),
        .IMM_MUX  (immMux),
        .MEM_MUX  (memMux),
        .rSrc     (rSrc),
        .rDst     (rDst),
        .aluOp    (aluOp),
        .pc       (pc),
        .imm      (imm),
        .mem_data (memData),
        .dSrc     (dSrc),
        .dDst     (dDst),
        .psrOut   (psrOut),
        .busy     (busy),
        .wb_valid (wbValid),
        .wb_data  (wbData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [4:0]   psr;
    } exp_t;

    exp_t       wbQ [$];
    longint     modelReg [NR];
    logic [4:0] mPsr;
    bit         lastMul;
    int         checks   = 0;
    int         failures = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    function automatic longint toSigned(input longint v);
        return (v >= HALF) ? v - (MASK + 1) : v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            modelReg[i] = 0;
        end
        mPsr    = '0;
        lastMul = 1'b0;
        wbQ.delete();
    endtask

    // Architectural model of one instruction. The PSR bits are {N,Z,F,L,C} = [4:0].
    task automatic modelExec(input int op, input longint a, input longint b, input bit memSel,
                             input longint memV, input longint pcV, input bit wr,
                             output bit hasWb, output longint res, output bit isMul);
        longint sa;
        longint sb;
        longint wide;
        bit     setZN;
        sa    = toSigned(a);
        sb    = toSigned(b);
        hasWb = 1'b0;
        res   = 0;
        isMul = 1'b0;
        setZN = 1'b0;
        if (memSel) begin
            res   = memV;
            hasWb = wr;
        end else begin
            case (op)
                OP_ADD: begin
                    wide    = a + b;
                    res     = wide & MASK;
                    mPsr[0] = (wide > MASK);
                    wide    = sa + sb;
                    mPsr[2] = (wide >= HALF) || (wide < -HALF);
                    hasWb   = wr;
                    setZN   = 1'b1;
                end
                OP_SUB: begin
                    res     = (a - b) & MASK;
                    mPsr[0] = (a < b);
                    wide    = sa - sb;
                    mPsr[2] = (wide >= HALF) || (wide < -HALF);
                    hasWb   = wr;
                    setZN   = 1'b1;
                end
                OP_AND: begin res = a & b; hasWb = wr; setZN = 1'b1; end
                OP_OR:  begin res = a | b; hasWb = wr; setZN = 1'b1; end
                OP_XOR: begin res = a ^ b; hasWb = wr; setZN = 1'b1; end
                OP_MOV: begin res = b;     hasWb = wr; setZN = 1'b1; end
                OP_CMP: begin
                    mPsr[3] = (a == b);
                    mPsr[1] = (a < b);
                    mPsr[4] = (sa < sb);
                end
                OP_LSH: begin res = (a << (b % W)) & MASK;   hasWb = wr; setZN = 1'b1; end
                OP_RSH: begin res = (sa >>> (b % W)) & MASK; hasWb = wr; setZN = 1'b1; end
                OP_MUL: begin
                    res   = (a * b) & MASK;
                    hasWb = wr;
                    setZN = 1'b1;
                    isMul = 1'b1;
                end
                OP_LINK: begin res = (pcV + 1) & MASK; hasWb = wr; end
                default: begin res = 0; end
            endcase
            if (setZN) begin
                mPsr[4] = (res >= HALF);
                mPsr[3] = (res == 0);
            end
        end
    endtask

    // Called at a negedge. Drives one instruction, holds valid_in until the DUT takes
    // it, and returns at the negedge after acceptance.
    task automatic applyStimulus(input int op, input int rs, input int rd, input longint immV,
                                 input bit immSel, input bit memSel, input longint memV,
                                 input longint pcV, input bit wr);
        longint a;
        longint b;
        longint res;
        bit     hasWb;
        bit     isMul;
        bit     wasBusy;
        bit     expectWait;
        int     waited;
        exp_t   e;
        expectWait = lastMul;
        valid_in   = 1'b1;
        aluOp      = 5'(op);
        rSrc       = 4'(rs);
        rDst       = 4'(rd);
        imm        = W'(immV);
        immMux     = immSel;
        memMux     = memSel;
        memData    = W'(memV);
        pc         = W'(pcV);
        wrEn       = wr;
        a = modelReg[rd];
        b = immSel ? (immV & MASK) : modelReg[rs];
        modelExec(op, a, b, memSel, memV & MASK, pcV & MASK, wr, hasWb, res, isMul);
        if (hasWb) begin
            modelReg[rd] = res;
            e.data = W'(res);
            e.psr  = mPsr;
            wbQ.push_back(e);
        end
        waited  = 0;
        wasBusy = busy;
        @(posedge clk);
        while (wasBusy && waited < TIMEOUT) begin
            waited++;
            @(negedge clk);
            wasBusy = busy;
            @(posedge clk);
        end
        @(negedge clk);
        valid_in = 1'b0;
        if (wasBusy) begin
            checks++;
            failures++;
            $display("[TB] FAIL issue_timeout: busy still 1 after %0d cycles, required 0", waited);
        end
        checkOutput("issue_wait", 64'(waited), expectWait ? 64'(W) : 64'd0);
        if (isMul) begin
            checkOutput("busy_after_mul", 64'(busy), 64'd1);
        end else begin
            checkOutput("psr_after_op", 64'(psrOut), 64'(mPsr));
        end
        lastMul = isMul;
    endtask

    task automatic expectReg(input string name, input int idx, input longint val);
        rSrc = 4'(idx);
        rDst = 4'(idx);
        #1;
        checkOutput(name, 64'(dSrc), 64'(val));
        checkOutput({name, "_dDst"}, 64'(dDst), 64'(val));
        @(negedge clk);
    endtask

    task automatic checkRegs();
        for (int i = 0; i < NR; i++) begin
            rSrc = 4'(i);
            rDst = 4'(NR - 1 - i);
            #1;
            checkOutput("readback_dSrc", 64'(dSrc), 64'(modelReg[i]));
            checkOutput("readback_dDst", 64'(dDst), 64'(modelReg[NR - 1 - i]));
            @(negedge clk);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < TIMEOUT) begin
            n++;
            @(negedge clk);
        end
        checkOutput("idle_reached", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        lastMul = 1'b0;
    endtask

    // Reset arrives a little after the eighth iteration edge of a multiply.
    task automatic resetMidMul();
        applyStimulus(OP_MOV, 0, 7, 64'h1234, 1'b1, 1'b0, 0, 0, 1'b1);
        applyStimulus(OP_MUL, 7, 7, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_psr", 64'(psrOut), 64'd0);
        checkOutput("rst_mid_wb_valid", 64'(wbValid), 64'd0);
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            rSrc = 4'(i);
            rDst = 4'(i);
            #1;
            checkOutput("rst_mid_reg", 64'(dSrc), 64'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    function automatic longint pickVal();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 1;
            2:       return HALF - 1;
            3:       return HALF;
            4:       return MASK;
            default: return longint'($urandom) & MASK;
        endcase
    endfunction

    // Scoreboard monitor: one expected entry per cycle with wb_valid.
    initial begin : monitor
        exp_t m;
        forever begin
            @(negedge clk);
            if (rst_n && wbValid) begin
                if (wbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_wb: got wb_data 0x%0h, required no write-back", wbData);
                end else begin
                    m = wbQ.pop_front();
                    checkOutput("wb_data", 64'(wbData), 64'(m.data));
                    checkOutput("wb_psr", 64'(psrOut), 64'(m.psr));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int op;
        modelReset();
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_wb_valid", 64'(wbValid), 64'd0);
        checkOutput("reset_psr", 64'(psrOut), 64'd0);
        checkOutput("reset_dSrc", 64'(dSrc), 64'd0);
        checkOutput("reset_dDst", 64'(dDst), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back dependency through forwarding, signed overflow into N.
        applyStimulus(OP_MOV, 0, 1, 64'h7FFF, 1'b1, 1'b0, 0, 0, 1'b1);
        applyStimulus(OP_MOV, 0, 2, 64'h0001, 1'b1, 1'b0, 0, 0, 1'b1);
        applyStimulus(OP_ADD, 2, 1, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        checkOutput("add_ovf_psr", 64'(psrOut), 64'b10100);
        expectReg("add_ovf_R1", 1, 64'h8000);

        // Borrow, then CMP of a register with itself.
        applyStimulus(OP_MOV, 0, 3, 64'h0005, 1'b1, 1'b0, 0, 0, 1'b1);
        applyStimulus(OP_SUB, 0, 3, 64'h0007, 1'b1, 1'b0, 0, 0, 1'b1);
        checkOutput("sub_C", 64'(psrOut[0]), 64'd1);
        checkOutput("sub_N", 64'(psrOut[4]), 64'd1);
        expectReg("sub_R3", 3, 64'hFFFE);
        applyStimulus(OP_CMP, 3, 3, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        checkOutput("cmp_Z", 64'(psrOut[3]), 64'd1);
        checkOutput("cmp_L", 64'(psrOut[1]), 64'd0);
        expectReg("cmp_R3_unchanged", 3, 64'hFFFE);

        // Multiply with a dependent op held on valid_in during busy.
        applyStimulus(OP_MOV, 0, 4, 64'h0123, 1'b1, 1'b0, 0, 0, 1'b1);
        applyStimulus(OP_MOV, 0, 5, 64'h0011, 1'b1, 1'b0, 0, 0, 1'b1);
        applyStimulus(OP_MUL, 5, 4, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        applyStimulus(OP_ADD, 0, 4, 64'h0000, 1'b1, 1'b0, 0, 0, 1'b1);
        expectReg("mul_R4", 4, 64'h1353);

        resetMidMul();
        applyStimulus(OP_ADD, 0, 1, 64'h0005, 1'b1, 1'b0, 0, 0, 1'b1);
        expectReg("add_after_reset", 1, 64'h0005);

        // LINK wrap and a load.
        applyStimulus(OP_LINK, 0, 8, 0, 1'b0, 1'b0, 0, 64'hFFFF, 1'b1);
        expectReg("link_wrap", 8, 64'h0000);
        applyStimulus(OP_ADD, 0, 9, 0, 1'b1, 1'b1, 64'hA5A5, 0, 1'b1);
        expectReg("mem_load", 9, 64'hA5A5);

        // Width boundaries.
        applyStimulus(OP_MOV, 0, 10, 64'hFFFF, 1'b1, 1'b0, 0, 0, 1'b1);
        applyStimulus(OP_ADD, 0, 10, 64'h0001, 1'b1, 1'b0, 0, 0, 1'b1);
        checkOutput("add_wrap_C", 64'(psrOut[0]), 64'd1);
        checkOutput("add_wrap_Z", 64'(psrOut[3]), 64'd1);
        expectReg("add_wrap_R10", 10, 64'h0000);
        applyStimulus(OP_MOV, 0, 11, 64'h8000, 1'b1, 1'b0, 0, 0, 1'b1);
        applyStimulus(OP_RSH, 0, 11, 64'd15, 1'b1, 1'b0, 0, 0, 1'b1);
        expectReg("rsh_max", 11, 64'hFFFF);
        applyStimulus(OP_MOV, 0, 12, 64'h0001, 1'b1, 1'b0, 0, 0, 1'b1);
        applyStimulus(OP_LSH, 0, 12, 64'd15, 1'b1, 1'b0, 0, 0, 1'b1);
        expectReg("lsh_max", 12, 64'h8000);

        // Random traffic, including undefined opcodes, loads and write=0.
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = int'($urandom_range(11, 31));
            end else begin
                op = int'($urandom_range(0, 10));
            end
            applyStimulus(op, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                          pickVal(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                          pickVal(), pickVal(), ($urandom_range(0, 5) != 0));
        end

        waitIdle();
        checkRegs();
        checkOutput("final_psr", 64'(psrOut), 64'(mPsr));
        checkOutput("queue_drained", 64'(wbQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
